// File: rtl/router_wrr_arbiter.sv
// Weighted matrix round-robin wormhole arbiter for one NoC router output port.
// Optional starvation guard: define ROUTER_ARB_STARVE_GUARD_EN.
module router_wrr_arbiter #(
    parameter int N_PORTS = 5,
    parameter int W_BITS  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          request,
    input  logic [N_PORTS-1:0]          forwarding_head,
    input  logic [N_PORTS-1:0]          forwarding_tail,
    input  logic [N_PORTS*W_BITS-1:0]   weight_cfg,
    output logic [N_PORTS-1:0]          grant,
    output logic                        grant_valid,
    output logic                        grant_locked
`ifdef ROUTER_ARB_STARVE_GUARD_EN
    ,
    output logic [N_PORTS-1:0]          starve_flag
`endif
);

    localparam int IW = $clog2(N_PORTS);

    typedef logic [N_PORTS-1:0][N_PORTS-1:0] mat_t;

    function automatic mat_t init_mask();
        mat_t m;
        for (int j = 0; j < N_PORTS; j++)
            for (int i = 0; i < N_PORTS; i++)
                m[j][i] = (j < i);
        return m;
    endfunction

    mat_t               mask_q, mask_d;
    logic [N_PORTS-1:0] lock_q;
    logic               lock_v;
    logic [IW-1:0]      holder_q, holder_d;
    logic               holder_v, holder_v_d;
    logic [W_BITS-1:0]  credit_q, credit_d;
    logic [N_PORTS-1:0] arb_grant;
    logic [IW-1:0]      g_idx;
    logic [W_BITS-1:0]  w_g, cnt;
    logic               head_q, tail_q;

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            arb_grant[i] = request[i];
            for (int j = 0; j < N_PORTS; j++)
                if (j != i && mask_q[j][i] && request[j])
                    arb_grant[i] = 1'b0;
        end
    end

    assign grant        = lock_v ? lock_q : arb_grant;
    assign grant_valid  = (|request) & ~lock_v;
    assign grant_locked = lock_v;
    assign head_q       = |(grant & forwarding_head);
    assign tail_q       = |(grant & forwarding_tail);

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N_PORTS; i++)
            if (grant[i]) g_idx = IW'(i);
    end

    always_comb begin
        w_g = weight_cfg[g_idx*W_BITS +: W_BITS];
        if (w_g == '0) w_g = W_BITS'(1);
        cnt = (holder_v && holder_q == g_idx) ? credit_q : w_g;
    end

`ifdef ROUTER_ARB_STARVE_GUARD_EN
    logic [N_PORTS-1:0][7:0] wait_q;
    logic [N_PORTS-1:0]      starving;
    logic [IW-1:0]           s_idx;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (rst || grant[i] || !request[i])
                wait_q[i] <= 8'd0;
            else if (wait_q[i] != 8'hff)
                wait_q[i] <= wait_q[i] + 8'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_PORTS; i++)
            starve_flag[i] = (wait_q[i] >= 8'd64);
        starving = starve_flag & ~grant;
        s_idx = '0;
        for (int i = N_PORTS - 1; i >= 0; i--)
            if (starving[i]) s_idx = IW'(i);
    end
`endif

    always_comb begin
        mask_d     = mask_q;
        holder_d   = holder_q;
        holder_v_d = holder_v;
        credit_d   = credit_q;
        if (tail_q) begin
            if (cnt <= W_BITS'(1)) begin
                for (int j = 0; j < N_PORTS; j++)
                    if (j != int'(g_idx)) begin
                        mask_d[j][g_idx] = 1'b1;
                        mask_d[g_idx][j] = 1'b0;
                    end
                holder_v_d = 1'b0;
                credit_d   = '0;
            end else begin
                for (int j = 0; j < N_PORTS; j++)
                    if (j != int'(g_idx)) begin
                        mask_d[g_idx][j] = 1'b1;
                        mask_d[j][g_idx] = 1'b0;
                    end
                holder_d   = g_idx;
                holder_v_d = 1'b1;
                credit_d   = cnt - W_BITS'(1);
            end
`ifdef ROUTER_ARB_STARVE_GUARD_EN
            // A starving port overrides whatever the credit logic chose
            if (|starving) begin
                for (int j = 0; j < N_PORTS; j++)
                    if (j != int'(s_idx)) begin
                        mask_d[s_idx][j] = 1'b1;
                        mask_d[j][s_idx] = 1'b0;
                    end
                holder_v_d = 1'b0;
                credit_d   = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q   <= init_mask();
            lock_v   <= 1'b0;
            lock_q   <= '0;
            holder_q <= '0;
            holder_v <= 1'b0;
            credit_q <= '0;
        end else begin
            mask_q   <= mask_d;
            holder_q <= holder_d;
            holder_v <= holder_v_d;
            credit_q <= credit_d;
            if (tail_q) begin
                lock_v <= 1'b0;
            end else if (head_q) begin
                lock_v <= 1'b1;
                lock_q <= grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant));
            assert (!(tail_q && grant == '0));
        end
    end

endmodule

// File: tb/tb_router_wrr_arbiter.sv
// Randomised bench for router_wrr_arbiter against a priority-list model,
// plus directed sequences with literal expectations.
module tb_router_wrr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  request, fh, ft;
    logic [14:0] weight_cfg;
    logic [4:0]  grant;
    logic        grant_valid, grant_locked;
`ifdef ROUTER_ARB_STARVE_GUARD_EN
    logic [4:0]  starve_flag;
`endif

    always #5 clk = ~clk;

    router_wrr_arbiter #(.N_PORTS(5), .W_BITS(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .request         (request),
        .forwarding_head (fh),
        .forwarding_tail (ft),
        .weight_cfg      (weight_cfg),
        .grant           (grant),
        .grant_valid     (grant_valid),
        .grant_locked    (grant_locked)
`ifdef ROUTER_ARB_STARVE_GUARD_EN
        ,
        .starve_flag     (starve_flag)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: priority as an ordered list, highest first
    int         order[$];
    bit         m_locked;
    int         m_lock_port;
    bit         m_hv;
    int         m_holder;
    int         m_credit;
    int         wt[5];
    logic [4:0] e_grant;
    logic       e_valid;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        order = {0, 1, 2, 3, 4};
        m_locked = 0; m_lock_port = 0;
        m_hv = 0; m_holder = 0; m_credit = 0;
    endfunction

    function automatic void move(input int p, input bit front);
        for (int k = 0; k < order.size(); k++)
            if (order[k] == p) begin
                order.delete(k);
                break;
            end
        if (front) order.push_front(p);
        else order.push_back(p);
    endfunction

    task automatic drive(input logic [4:0] rq, input logic [4:0] hd,
                         input logic [4:0] tl, input logic r);
        request = rq; fh = hd; ft = tl; rst = r;
        for (int i = 0; i < 5; i++) weight_cfg[i*3 +: 3] = 3'(wt[i]);
        #1;
        e_grant = '0;
        if (m_locked) begin
            e_grant[m_lock_port] = 1'b1;
        end else begin
            foreach (order[k])
                if (rq[order[k]]) begin
                    e_grant[order[k]] = 1'b1;
                    break;
                end
        end
        e_valid = (|rq) && !m_locked;
        if (!r) begin
            chk("grant", grant, e_grant);
            chk("grant_valid", grant_valid, e_valid);
            chk("grant_locked", grant_locked, m_locked);
        end
    endtask

    task automatic advance();
        int g, cnt, w;
        g = 0;
        for (int i = 0; i < 5; i++) if (e_grant[i]) g = i;
        if (rst) begin
            model_reset();
        end else if (|(e_grant & ft)) begin
            m_locked = 0;
            w = (wt[g] == 0) ? 1 : wt[g];
            cnt = (m_hv && m_holder == g) ? m_credit : w;
            if (cnt <= 1) begin
                move(g, 0); m_hv = 0; m_credit = 0;
            end else begin
                move(g, 1); m_hv = 1; m_holder = g; m_credit = cnt - 1;
            end
        end else if (|(e_grant & fh)) begin
            m_locked = 1; m_lock_port = g;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        advance();
    endtask

    function automatic int idx(input logic [4:0] v);
        int r = -1;
        for (int i = 0; i < 5; i++) if (v[i]) r = i;
        return r;
    endfunction

    int exp3[10]  = '{0, 0, 0, 1, 2, 3, 4, 0, 0, 0};
    int exp4[14]  = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 0, 1, 2};

    initial begin
        model_reset();
        wt = '{1, 1, 1, 1, 1};
        do_reset();

        // Reset state and a locked packet with request changes mid-flight
        drive(5'b10110, 5'b0, 5'b0, 1'b0);
        chk("reset_grant", grant, 5'b00010);
        chk("reset_valid", grant_valid, 1);
        chk("reset_locked", grant_locked, 0);
        advance();
        drive(5'b10110, 5'b00010, 5'b0, 1'b0);
        chk("head_grant", grant, 5'b00010);
        advance();
        for (int c = 0; c < 2; c++) begin
            drive(5'b10101, 5'b0, 5'b0, 1'b0);
            chk("held_grant", grant, 5'b00010);
            chk("held_valid", grant_valid, 0);
            chk("held_locked", grant_locked, 1);
            advance();
        end
        drive(5'b10101, 5'b0, 5'b00010, 1'b0);
        chk("tail_grant", grant, 5'b00010);
        chk("tail_valid", grant_valid, 0);
        advance();
        drive(5'b10110, 5'b0, 5'b0, 1'b0);
        chk("after_tail_grant", grant, 5'b00100);
        chk("after_tail_locked", grant_locked, 0);
        advance();

        // Weight 3 on port 0, single-flit packets
        wt = '{3, 1, 1, 1, 1};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(5'b11111, 5'b11111, 5'b11111, 1'b0);
            chk($sformatf("w3_seq%0d", c), idx(grant), exp3[c]);
            advance();
        end

        // Weight 0 on port 2, weight 7 on port 4
        wt = '{1, 1, 0, 1, 7};
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive(5'b11111, 5'b11111, 5'b11111, 1'b0);
            chk($sformatf("w7_seq%0d", c), idx(grant), exp4[c]);
            advance();
        end

        // Reset while locked with a partly used credit
        wt = '{3, 1, 1, 1, 1};
        do_reset();
        for (int c = 0; c < 2; c++) begin
            drive(5'b11111, 5'b11111, 5'b11111, 1'b0);
            advance();
        end
        drive(5'b11111, 5'b00001, 5'b0, 1'b0);
        advance();
        drive(5'b11111, 5'b0, 5'b0, 1'b0);
        chk("prerst_locked", grant_locked, 1);
        advance();
        do_reset();
        drive(5'b11111, 5'b11111, 5'b11111, 1'b0);
        chk("postrst_locked", grant_locked, 0);
        chk("postrst_grant", grant, 5'b00001);
        advance();
        drive(5'b11111, 5'b0, 5'b0, 1'b0);
        chk("credit_cleared", grant, 5'b00001);
        advance();

        // Randomised traffic, weights fixed per round
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 5; i++) wt[i] = $urandom_range(0, 7);
            do_reset();
            for (int c = 0; c < 400; c++) begin
                drive(5'($urandom), 5'($urandom & $urandom),
                      5'($urandom & $urandom), 1'b0);
                advance();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
